// File: rtl/teclado_cajero_if.sv
// Cashier-side outputs of the keypad front end: PIN digits, amount and transaction type.
interface teclado_cajero_if;
    logic [4:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        TIPO_TRANS;
    logic        FASE_MONTO;

    modport master (
        output DIGITO, DIGITO_STB, MONTO, MONTO_STB, TIPO_TRANS, FASE_MONTO
    );

    modport slave (
        input DIGITO, DIGITO_STB, MONTO, MONTO_STB, TIPO_TRANS, FASE_MONTO
    );
endinterface

// File: rtl/teclado_cajero.sv
// 4x4 ATM keypad scanner/debouncer with PIN digit streaming and decimal amount entry.
// Optional inactivity timeout is built only when TECLADO_TIMEOUT_EN is defined.
module teclado_cajero #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEB_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              TARJETA_RECIBIDA,
    input  logic [3:0]        FILAS,
    output logic [3:0]        COLUMNAS,
    teclado_cajero_if.master  cajero
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {ESCANEO, REBOTE, PULSADA, SOLTAR} escaneo_e;
    typedef enum logic {EN_PIN, EN_MONTO} entrada_e;

    escaneo_e    scan_q, scan_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  fila_q, fila_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  deb_q, deb_d;
    logic [3:0]  filas_q, filas_d;
    logic        una_fila;
    logic [1:0]  fila_baja;
    logic        tecla_evt;

    entrada_e    entrada_q, entrada_d;
    logic [1:0]  pin_q, pin_d;
    logic [31:0] monto_q, monto_d;
    logic        tipo_q, tipo_d;
    logic [4:0]  digito_q, digito_d;
    logic        dstb_q, dstb_d;
    logic        mstb_q, mstb_d;

    logic        es_digito, es_letra;
    logic [3:0]  valor;
    logic [1:0]  letra;
    logic [35:0] monto_x10;
    logic        timeout;

    // Multiple simultaneous rows are ambiguous and treated as no press.
    always_comb begin
        una_fila  = 1'b1;
        fila_baja = 2'd0;
        case (FILAS)
            4'b1110: fila_baja = 2'd0;
            4'b1101: fila_baja = 2'd1;
            4'b1011: fila_baja = 2'd2;
            4'b0111: fila_baja = 2'd3;
            default: una_fila  = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_q  <= ESCANEO;
            col_q   <= 2'd0;
            fila_q  <= 2'd0;
            div_q   <= 8'd0;
            deb_q   <= 8'd0;
            filas_q <= 4'hF;
        end else begin
            scan_q  <= scan_d;
            col_q   <= col_d;
            fila_q  <= fila_d;
            div_q   <= div_d;
            deb_q   <= deb_d;
            filas_q <= filas_d;
        end
    end

    always_comb begin
        scan_d  = scan_q;
        col_d   = col_q;
        fila_d  = fila_q;
        div_d   = div_q;
        deb_d   = deb_q;
        filas_d = filas_q;
        unique case (scan_q)
            ESCANEO: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (una_fila) begin
                        scan_d  = REBOTE;
                        filas_d = FILAS;
                        fila_d  = fila_baja;
                        deb_d   = 8'd0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            REBOTE: begin
                if (FILAS == filas_q) begin
                    if (deb_q == DEB_LAST) scan_d = PULSADA;
                    else                   deb_d  = deb_q + 8'd1;
                end else begin
                    scan_d = ESCANEO;
                    col_d  = col_q + 2'd1;
                end
            end
            PULSADA: begin
                scan_d = SOLTAR;
                deb_d  = 8'd0;
            end
            SOLTAR: begin
                if (FILAS == 4'hF) begin
                    if (deb_q == DEB_LAST) begin
                        scan_d = ESCANEO;
                        col_d  = 2'd0;
                        div_d  = 8'd0;
                    end else begin
                        deb_d = deb_q + 8'd1;
                    end
                end else begin
                    deb_d = 8'd0;
                end
            end
            default: scan_d = ESCANEO;
        endcase
    end

    // Column 3 holds A..D; row 3 holds * 0 #, of which only 0 is kept.
    always_comb begin
        es_digito = 1'b0;
        es_letra  = 1'b0;
        valor     = 4'd0;
        letra     = fila_q;
        if (col_q == 2'd3) begin
            es_letra = 1'b1;
        end else if (fila_q != 2'd3) begin
            es_digito = 1'b1;
            valor     = {2'b00, fila_q} * 4'd3 + {2'b00, col_q} + 4'd1;
        end else if (col_q == 2'd1) begin
            es_digito = 1'b1;
        end
    end

    assign monto_x10 = {4'b0000, monto_q} * 36'd10 + {32'd0, valor};

`ifdef TECLADO_TIMEOUT_EN
    logic [31:0] ocio_q;
    logic        sesion_vacia;

    assign sesion_vacia = (entrada_q == EN_PIN) && (pin_q == 2'd0) && (monto_q == 32'd0);
    assign timeout      = (ocio_q == 32'(TIMEOUT_CYCLES)) && !sesion_vacia;

    // Saturates at the limit; only key events or a new card restart it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ocio_q <= 32'd0;
        end else if (tecla_evt || TARJETA_RECIBIDA) begin
            ocio_q <= 32'd0;
        end else if (ocio_q != 32'(TIMEOUT_CYCLES)) begin
            ocio_q <= ocio_q + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            entrada_q <= EN_PIN;
            pin_q     <= 2'd0;
            monto_q   <= 32'd0;
            tipo_q    <= 1'b0;
            digito_q  <= 5'd0;
            dstb_q    <= 1'b0;
            mstb_q    <= 1'b0;
        end else begin
            entrada_q <= entrada_d;
            pin_q     <= pin_d;
            monto_q   <= monto_d;
            tipo_q    <= tipo_d;
            digito_q  <= digito_d;
            dstb_q    <= dstb_d;
            mstb_q    <= mstb_d;
        end
    end

    always_comb begin
        entrada_d = entrada_q;
        pin_d     = pin_q;
        monto_d   = monto_q;
        tipo_d    = tipo_q;
        digito_d  = digito_q;
        dstb_d    = 1'b0;
        mstb_d    = 1'b0;
        if (TARJETA_RECIBIDA) begin
            entrada_d = EN_PIN;
            pin_d     = 2'd0;
            monto_d   = 32'd0;
            tipo_d    = 1'b0;
        end else if (timeout) begin
            entrada_d = EN_PIN;
            pin_d     = 2'd0;
            monto_d   = 32'd0;
        end else if (tecla_evt) begin
            unique case (entrada_q)
                EN_PIN: begin
                    if (es_digito) begin
                        digito_d = {1'b0, valor};
                        dstb_d   = 1'b1;
                        if (pin_q == 2'd3) begin
                            entrada_d = EN_MONTO;
                            pin_d     = 2'd0;
                            monto_d   = 32'd0;
                            tipo_d    = 1'b0;
                        end else begin
                            pin_d = pin_q + 2'd1;
                        end
                    end
                end
                EN_MONTO: begin
                    if (es_digito && (monto_x10[35:32] == 4'd0)) begin
                        monto_d = monto_x10[31:0];
                    end else if (es_letra) begin
                        unique case (letra)
                            2'd0: tipo_d  = 1'b0;
                            2'd1: tipo_d  = 1'b1;
                            2'd2: monto_d = 32'd0;
                            2'd3: mstb_d  = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tecla_evt         = (scan_q == PULSADA);
        COLUMNAS          = ~(4'b0001 << col_q);
        cajero.DIGITO     = digito_q;
        cajero.DIGITO_STB = dstb_q;
        cajero.MONTO      = monto_q;
        cajero.MONTO_STB  = mstb_q;
        cajero.TIPO_TRANS = tipo_q;
        cajero.FASE_MONTO = (entrada_q == EN_MONTO);
    end

endmodule
